// File: rtl/dot_product_sequencer.sv
// Sequences a signed fixed-point dot product over two memory vectors through an external multiplier.
// Latency: len*(MUL_LAT+3)+1 cycles from start acceptance to done; one element in flight at a time.
// Backpressure: none; start is taken only in IDLE and ignored otherwise, memory and multiplier are fixed-latency.
module dot_product_sequencer #(
    parameter int N       = 16,
    parameter int Q       = 12,
    parameter int LEN_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_x,
    input  logic [ADDR_W-1:0] base_w,
    output logic              rd_en,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [N-1:0]      x_data,
    input  logic [N-1:0]      w_data,
    output logic              mul_start,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [N-1:0]      mul_result,
    input  logic              mul_overflow,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic              overflow
);

    localparam int ACC_W = N + LEN_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(LEN_W+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(LEN_W+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [3:0] WAIT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, MUL, WAIT, ACC, DONE} state_t;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         len_r;
    logic [LEN_W-1:0]         idx;
    logic [LEN_W:0]           idx_inc;
    logic [ADDR_W-1:0]        base_x_r, base_w_r;
    logic signed [ACC_W-1:0]  acc, acc_sum, mul_ext;
    logic                     sticky;
    logic [3:0]               wcnt;
    logic                     last_elem, sat_hi, sat_lo;
    logic [31:0]              unused_q;

    // Q only names the operand format; a fixed-point sum is format-agnostic.
    assign unused_q  = 32'(Q);

    assign mul_ext   = {{LEN_W{mul_result[N-1]}}, mul_result};
    assign acc_sum   = acc + mul_ext;
    assign sat_hi    = acc_sum > ACC_MAX;
    assign sat_lo    = acc_sum < ACC_MIN;
    assign idx_inc   = {1'b0, idx} + {{LEN_W{1'b0}}, 1'b1};
    assign last_elem = idx_inc >= {1'b0, len_r};

    assign rd_en     = (state == FETCH);
    assign mul_start = (state == MUL);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign x_addr    = (state == FETCH) ? base_x_r + ADDR_W'(idx) : '0;
    assign w_addr    = (state == FETCH) ? base_w_r + ADDR_W'(idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = MUL;
            MUL:     state_nxt = (MUL_LAT > 1) ? WAIT : ACC;
            WAIT:    if (wcnt <= 4'd1) state_nxt = ACC;
            ACC:     state_nxt = last_elem ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay registered from LOAD until the next LOAD, covering the whole multiply window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r    <= '0;
            base_x_r <= '0;
            base_w_r <= '0;
            idx      <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            wcnt     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r    <= len;
                        base_x_r <= base_x;
                        base_w_r <= base_w;
                        idx      <= '0;
                        acc      <= '0;
                        sticky   <= 1'b0;
                        if (len == '0) begin
                            result   <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    mul_a <= x_data;
                    mul_b <= w_data;
                end
                MUL:  wcnt <= WAIT_INIT;
                WAIT: wcnt <= wcnt - 4'd1;
                ACC: begin
                    acc    <= acc_sum;
                    sticky <= sticky | mul_overflow;
                    idx    <= idx + 1'b1;
                    if (last_elem) begin
                        if (sat_hi)      result <= {1'b0, {(N-1){1'b1}}};
                        else if (sat_lo) result <= {1'b1, {(N-1){1'b0}}};
                        else             result <= acc_sum[N-1:0];
                        overflow <= sticky | mul_overflow | sat_hi | sat_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameters SHALL be: N, default 16, data word width; Q, default 12, fractional bits; LEN_W, default 8, length width; ADDR_W, default 8, memory address width; MUL_LAT, default 2 (range 1..8), external multiplier latency in cycles.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to begin a dot product; honoured only in IDLE.
REQ-005 len  in  LEN_W  element count, sampled on accepted start.
REQ-006 base_x, base_w  in  ADDR_W each  start addresses of the input and weight vectors, sampled on accepted start.
REQ-007 rd_en  out  1  memory read strobe.
REQ-008 x_addr, w_addr  out  ADDR_W each  read addresses, valid while rd_en=1.
REQ-009 x_data, w_data  in  N each  signed Q(N-Q).Q read data, valid exactly 1 cycle after rd_en.
REQ-010 mul_start  out  1  one-cycle start pulse to the fixed-point multiplier.
REQ-011 mul_a, mul_b  out  N each  multiplier operands, held stable from the mul_start cycle until the result is sampled.
REQ-012 mul_result  in  N  signed Q-format product.
REQ-013 mul_overflow  in  1  multiplier overflow flag, sampled with mul_result.
REQ-014 busy  out  1  high from the cycle after start acceptance through the DONE cycle.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 result  out  N  saturated signed Q-format dot product.
REQ-017 overflow  out  1  high if any product overflowed or the final value saturated.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LOAD, MUL, WAIT, ACC, DONE.
REQ-019 IDLE with start=1: latch len/bases, clear accumulator and sticky flag, then go to FETCH, or to DONE if len=0.
REQ-020 FETCH: rd_en=1, x_addr=base_x+i, w_addr=base_w+i (i = element index, mod 2^ADDR_W wrap-around); next LOAD.
REQ-021 LOAD: register x_data into mul_a and w_data into mul_b; next MUL.
REQ-022 MUL: mul_start=1 for exactly this cycle; next WAIT if MUL_LAT>1, else ACC.
REQ-023 WAIT: lasts MUL_LAT-1 cycles (internal counter), then ACC.
REQ-024 ACC (MUL_LAT cycles after MUL): sign-extend mul_result into an N+LEN_W-bit signed accumulator and add; OR mul_overflow into the sticky flag; i++; next FETCH if i<len, else DONE.
REQ-025 Per-element cost SHALL be exactly MUL_LAT+3 cycles; done SHALL assert exactly len*(MUL_LAT+3)+1 cycles after the start-acceptance edge (1 cycle for len=0).
REQ-026 Entering DONE: result = accumulator clamped to [0x8000,0x7FFF] (N=16); overflow = sticky OR clamp-occurred; both held until the next DONE.
REQ-027 DONE: done=1 for one cycle; next IDLE unconditionally; start in any non-IDLE state (including DONE) SHALL be ignored, not queued.
REQ-028 rd_en and mul_start SHALL be 0 in every state except FETCH and MUL respectively.
REQ-029 len, base_x and base_w changes while busy SHALL have no effect.

Reset
REQ-030 rst_n=0 at any time, including mid-operation, SHALL immediately force IDLE with busy, done, rd_en, mul_start, result, overflow, mul_a, mul_b, addresses, accumulator and counters all zero.
REQ-031 After rst_n rises, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-032 len=2, x=[0x1000,0x2000], w=[0x3006,0x1000], MUL_LAT=2, ideal multiplier -> done 11 cycles after start, result=0x5006, overflow=0.
REQ-033 len=2, x=[0x7000,0x7000], w=[0x1000,0x1000] -> result=0x7FFF, overflow=1; repeat with x=[0x9000,0x9000] -> result=0x8000, overflow=1.
REQ-034 len=0 -> done on the next cycle, result=0x0000, overflow=0, no rd_en or mul_start pulses.
REQ-035 mul_overflow forced high on element 1 of 3, in-range sum -> overflow=1, result equals the unsaturated sum.
REQ-036 start re-asserted while busy and in DONE, plus rst_n pulsed low mid-WAIT -> no second run, outputs zero immediately on reset, next start runs cleanly.
REQ-037 base_x=0xFF, len=2 -> x_addr sequence 0xFF then 0x00; rd_en and mul_start pulse counts equal len.
